elevator_scheduler: RTL and testbench

//  Request scheduler and motion/door sequencer for the 4-floor elevator core.
//  - Latches cab and hall calls; runs collective SCAN (keep direction while calls lie ahead).
//  - Tracks current floor from the shaft floor-sensor pulse.
//  - Drives Level, AbreCierra (door) and SubeBaja (direction/motor) toward the Interface

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elevator_call_latch.sv | 101 ++++++++++
 rtl/elevator_scheduler.sv | 163 ++++++++++++++++
 tb/tb_elevator_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and constants for the elevator scheduler
// Contents:
//   NFLOORS_DEF  default floor count
//   FW           floor index width for the default floor count
//   DIR_UP/DIR_DN  values carried on SubeBaja
//   state_e      scheduler FSM states
package elevator_pkg;
  localparam int NFLOORS_DEF = 4;
  localparam int FW          = $clog2(NFLOORS_DEF);

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEPART = 2'd1,
    MOVING = 2'd2,
    DOOR   = 2'd3
  } state_e;
endpackage

// File: rtl/elevator_call_latch.sv
// rtl/elevator_call_latch.sv - cab/hall call latches with look-ahead flags
// Ports:
//   clk, reset                 clock, async active-low reset
//   req_cab/req_up/req_dn      raw call inputs (up at top floor and down at floor 0 ignored)
//   lvl, dir                   floor and direction the flags are evaluated against
//   door_here                  door is open at lvl: calls at lvl are refused
//   clr_cab/clr_up/clr_dn      clear the corresponding latch at lvl on this edge
//   pending                    OR of latched calls per floor
//   cab_here/up_here/dn_here   call (latched or arriving now) at lvl
//   req_here                   a valid call input is asserted at lvl this cycle
//   ahead/behind               any call beyond lvl in / against dir
//   near_up                    nearest call lies above (ties resolve up)
//   any_call                   any call latched or arriving
module elevator_call_latch
  import elevator_pkg::*;
#(
  parameter  int NFLOORS = NFLOORS_DEF,
  localparam int LW      = $clog2(NFLOORS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] req_cab,
  input  logic [NFLOORS-1:0] req_up,
  input  logic [NFLOORS-1:0] req_dn,
  input  logic [LW-1:0]      lvl,
  input  logic               dir,
  input  logic               door_here,
  input  logic               clr_cab,
  input  logic               clr_up,
  input  logic               clr_dn,
  output logic [NFLOORS-1:0] pending,
  output logic               cab_here,
  output logic               up_here,
  output logic               dn_here,
  output logic               req_here,
  output logic               ahead,
  output logic               behind,
  output logic               near_up,
  output logic               any_call
);
  logic [NFLOORS-1:0] cab_q, up_q, dn_q;
  logic [NFLOORS-1:0] in_cab, in_up, in_dn;
  logic [NFLOORS-1:0] cab_s, up_s, dn_s, all_s;
  logic [NFLOORS-1:0] lvl_bit, above, below;
  int                 d_up, d_dn;

  always_comb begin
    lvl_bit      = '0;
    lvl_bit[lvl] = 1'b1;
    in_cab       = req_cab;
    in_up        = req_up;
    in_dn        = req_dn;
    in_up[NFLOORS-1] = 1'b0;
    in_dn[0]         = 1'b0;
    req_here = |((in_cab | in_up | in_dn) & lvl_bit);
    // A call at an open door is served by holding the door, not by latching it.
    if (door_here) begin
      in_cab = in_cab & ~lvl_bit;
      in_up  = in_up & ~lvl_bit;
      in_dn  = in_dn & ~lvl_bit;
    end
    // Decisions see calls arriving this cycle, so a call at the new floor stops the car.
    cab_s = cab_q | in_cab;
    up_s  = up_q | in_up;
    dn_s  = dn_q | in_dn;
    all_s = cab_s | up_s | dn_s;

    above = '0;
    below = '0;
    d_up  = NFLOORS;
    d_dn  = NFLOORS;
    for (int i = 0; i < NFLOORS; i++) begin
      above[i] = (i > int'(lvl));
      below[i] = (i < int'(lvl));
      if (all_s[i] && i > int'(lvl) && (i - int'(lvl)) < d_up) d_up = i - int'(lvl);
      if (all_s[i] && i < int'(lvl) && (int'(lvl) - i) < d_dn) d_dn = int'(lvl) - i;
    end

    cab_here = |(cab_s & lvl_bit);
    up_here  = |(up_s & lvl_bit);
    dn_here  = |(dn_s & lvl_bit);
    ahead    = dir ? |(all_s & above) : |(all_s & below);
    behind   = dir ? |(all_s & below) : |(all_s & above);
    near_up  = (d_up <= d_dn);
    any_call = |all_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cab_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      cab_q <= cab_s & ~({NFLOORS{clr_cab}} & lvl_bit);
      up_q  <= up_s & ~({NFLOORS{clr_up}} & lvl_bit);
      dn_q  <= dn_s & ~({NFLOORS{clr_dn}} & lvl_bit);
    end
  end

  assign pending = cab_q | up_q | dn_q;
endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - collective SCAN scheduler and motion/door sequencer
// Optional feature macro: EMERGENCY_STOP_EN (adds estop input that freezes the sequencer).
// Ports:
//   clk, reset                 clock, async active-low reset
//   req_cab/req_up/req_dn      cab and hall call inputs, one bit per floor
//   floor_tick                 one-cycle pulse, car reached the next floor
//   door_reopen                obstruction / door-open button
//   estop                      (EMERGENCY_STOP_EN only) hold everything except call latching
//   Level                      current floor, 0-based
//   AbreCierra                 1 = door open
//   SubeBaja                   1 = up, 0 = down
//   moving                     motor enable
//   pending                    latched calls per floor
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter  int NFLOORS    = NFLOORS_DEF,
  parameter  int DOOR_TICKS = 8,
  parameter  int DEPART_DLY = 2,
  localparam int LW         = $clog2(NFLOORS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] req_cab,
  input  logic [NFLOORS-1:0] req_up,
  input  logic [NFLOORS-1:0] req_dn,
  input  logic               floor_tick,
  input  logic               door_reopen,
`ifdef EMERGENCY_STOP_EN
  input  logic               estop,
`endif
  output logic [LW-1:0]      Level,
  output logic               AbreCierra,
  output logic               SubeBaja,
  output logic               moving,
  output logic [NFLOORS-1:0] pending
);
  localparam int TMAX = (DOOR_TICKS > DEPART_DLY) ? DOOR_TICKS : DEPART_DLY;
  localparam int TW   = $clog2(TMAX + 1);

  state_e        state_q, state_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic [LW-1:0] lvl_n;
  logic          dir_n, hold, at_limit, step_ok, open;
  logic          clr_cab, clr_up, clr_dn;
  logic          cab_here, up_here, dn_here, req_here;
  logic          ahead, behind, near_up, any_call;

`ifdef EMERGENCY_STOP_EN
  assign hold = estop;
`else
  assign hold = 1'b0;
`endif

  // Next floor is resolved first so the call flags below refer to the floor being arrived at.
  always_comb begin
    at_limit = SubeBaja ? (Level == LW'(NFLOORS - 1)) : (Level == '0);
    step_ok  = !hold && (state_q == MOVING) && floor_tick && !at_limit;
    lvl_n    = Level;
    if (step_ok) lvl_n = SubeBaja ? Level + 1'b1 : Level - 1'b1;
  end

  elevator_call_latch #(.NFLOORS(NFLOORS)) u_calls (
    .clk       (clk),
    .reset     (reset),
    .req_cab   (req_cab),
    .req_up    (req_up),
    .req_dn    (req_dn),
    .lvl       (lvl_n),
    .dir       (SubeBaja),
    .door_here (state_q == DOOR),
    .clr_cab   (clr_cab),
    .clr_up    (clr_up),
    .clr_dn    (clr_dn),
    .pending   (pending),
    .cab_here  (cab_here),
    .up_here   (up_here),
    .dn_here   (dn_here),
    .req_here  (req_here),
    .ahead     (ahead),
    .behind    (behind),
    .near_up   (near_up),
    .any_call  (any_call)
  );

  always_comb begin
    state_n = state_q;
    tmr_n   = tmr_q;
    dir_n   = SubeBaja;
    open    = 1'b0;
    clr_cab = 1'b0;
    clr_up  = 1'b0;
    clr_dn  = 1'b0;
    if (!hold) begin
      case (state_q)
        IDLE: begin
          if (cab_here || up_here || dn_here) begin
            open = 1'b1;
          end else if (any_call) begin
            dir_n   = near_up ? DIR_UP : DIR_DN;
            state_n = DEPART;
            tmr_n   = TW'(DEPART_DLY);
          end
        end
        DEPART: begin
          if (tmr_q <= TW'(1)) state_n = MOVING;
          else                 tmr_n   = tmr_q - 1'b1;
        end
        MOVING: begin
          if (step_ok && (cab_here || (SubeBaja ? up_here : dn_here) || !ahead)) open = 1'b1;
        end
        DOOR: begin
          // Reopen (or a fresh call here) beats expiry in the same cycle.
          if (door_reopen || req_here) begin
            tmr_n = TW'(DOOR_TICKS);
          end else if (tmr_q <= TW'(1)) begin
            if (ahead) begin
              state_n = DEPART;
              tmr_n   = TW'(DEPART_DLY);
            end else if (behind) begin
              dir_n   = ~SubeBaja;
              state_n = DEPART;
              tmr_n   = TW'(DEPART_DLY);
            end else begin
              state_n = IDLE;
            end
          end else begin
            tmr_n = tmr_q - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Door entry: serve the floor; with nothing ahead the car turns around here,
    // so the opposite hall call is served as well.
    if (open) begin
      state_n = DOOR;
      tmr_n   = TW'(DOOR_TICKS);
      clr_cab = 1'b1;
      clr_up  = SubeBaja || !ahead;
      clr_dn  = !SubeBaja || !ahead;
      if (!ahead) dir_n = ~SubeBaja;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      Level      <= '0;
      SubeBaja   <= DIR_UP;
      AbreCierra <= 1'b0;
      moving     <= 1'b0;
    end else begin
      state_q    <= state_n;
      tmr_q      <= tmr_n;
      Level      <= lvl_n;
      SubeBaja   <= dir_n;
      AbreCierra <= (state_n == DOOR);
      moving     <= (state_n == MOVING) && !hold;
    end
  end
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - self-checking bench for elevator_scheduler
module tb_elevator_scheduler;
  localparam int NF = 4;
  localparam int DT = 8;
  localparam int DD = 2;
  localparam int M_IDLE = 0, M_DEP = 1, M_MOV = 2, M_DOOR = 3;

  logic          clk, reset;
  logic [NF-1:0] req_cab, req_up, req_dn;
  logic          floor_tick, door_reopen;
`ifdef EMERGENCY_STOP_EN
  logic          estop;
`endif
  logic [1:0]    Level;
  logic          AbreCierra, SubeBaja, moving;
  logic [NF-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [NF-1:0] m_cab, m_up, m_dn;
  int m_lvl, m_dir, m_st, m_tmr;
  bit m_door, m_mov;

  elevator_scheduler #(.NFLOORS(NF), .DOOR_TICKS(DT), .DEPART_DLY(DD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_cab     (req_cab),
    .req_up      (req_up),
    .req_dn      (req_dn),
    .floor_tick  (floor_tick),
    .door_reopen (door_reopen),
`ifdef EMERGENCY_STOP_EN
    .estop       (estop),
`endif
    .Level       (Level),
    .AbreCierra  (AbreCierra),
    .SubeBaja    (SubeBaja),
    .moving      (moving),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_calls_dir(int d);
    logic [NF-1:0] all;
    all = m_cab | m_up | m_dn;
    for (int f = 0; f < NF; f++)
      if (all[f] && ((d == 1 && f > m_lvl) || (d == 0 && f < m_lvl))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ahead();
    return m_calls_dir(m_dir);
  endfunction

  function automatic int m_nearest_dir();
    logic [NF-1:0] all;
    int du, dd;
    all = m_cab | m_up | m_dn;
    du = 99;
    dd = 99;
    for (int f = 0; f < NF; f++) begin
      if (all[f] && f > m_lvl && f - m_lvl < du) du = f - m_lvl;
      if (all[f] && f < m_lvl && m_lvl - f < dd) dd = m_lvl - f;
    end
    return (du <= dd) ? 1 : 0;
  endfunction

  task automatic m_open_door();
    m_st = M_DOOR;
    m_tmr = DT;
    m_cab[m_lvl] = 1'b0;
    if (m_dir == 1) m_up[m_lvl] = 1'b0;
    else            m_dn[m_lvl] = 1'b0;
    if (!m_ahead()) begin
      m_dir = 1 - m_dir;
      if (m_dir == 1) m_up[m_lvl] = 1'b0;
      else            m_dn[m_lvl] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_cab = '0; m_up = '0; m_dn = '0;
    m_lvl = 0; m_dir = 1; m_st = M_IDLE; m_tmr = 0;
    m_door = 0; m_mov = 0;
  endtask

  task automatic model_step();
    logic [NF-1:0] ic, iu, id;
    bit hold, restart;
    hold = 1'b0;
`ifdef EMERGENCY_STOP_EN
    hold = estop;
`endif
    ic = req_cab; iu = req_up; id = req_dn;
    iu[NF-1] = 1'b0;
    id[0] = 1'b0;
    restart = 1'b0;
    if (m_st == M_DOOR && (ic[m_lvl] || iu[m_lvl] || id[m_lvl])) begin
      restart = 1'b1;
      ic[m_lvl] = 1'b0; iu[m_lvl] = 1'b0; id[m_lvl] = 1'b0;
    end
    m_cab |= ic; m_up |= iu; m_dn |= id;
    if (!hold) begin
      case (m_st)
        M_IDLE: begin
          if ((m_cab | m_up | m_dn) & (4'b0001 << m_lvl)) m_open_door();
          else if ((m_cab | m_up | m_dn) != '0) begin
            m_dir = m_nearest_dir(); m_st = M_DEP; m_tmr = DD;
          end
        end
        M_DEP: if (m_tmr == 1) m_st = M_MOV; else m_tmr--;
        M_MOV: begin
          if (floor_tick && ((m_dir == 1 && m_lvl < NF - 1) || (m_dir == 0 && m_lvl > 0))) begin
            m_lvl = m_lvl + ((m_dir == 1) ? 1 : -1);
            if (m_cab[m_lvl] || (m_dir == 1 ? m_up[m_lvl] : m_dn[m_lvl]) || !m_ahead()) m_open_door();
          end
        end
        default: begin
          if (door_reopen || restart) m_tmr = DT;
          else if (m_tmr == 1) begin
            if (m_ahead()) begin m_st = M_DEP; m_tmr = DD; end
            else if (m_calls_dir(1 - m_dir)) begin m_dir = 1 - m_dir; m_st = M_DEP; m_tmr = DD; end
            else m_st = M_IDLE;
          end else m_tmr--;
        end
      endcase
    end
    m_door = (m_st == M_DOOR);
    m_mov  = (m_st == M_MOV) && !hold;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_tick();
    floor_tick = 1'b1;
    step();
    floor_tick = 1'b0;
  endtask

  task automatic wait_moving(output int cycles);
    cycles = 0;
    while (moving !== 1'b1 && cycles < 20) begin step(); cycles++; end
  endtask

  task automatic wait_door_closed(output int cycles);
    cycles = 0;
    while (AbreCierra === 1'b1 && cycles < 40) begin step(); cycles++; end
  endtask

  task automatic do_reset();
    req_cab = '0; req_up = '0; req_dn = '0;
    floor_tick = 1'b0; door_reopen = 1'b0;
`ifdef EMERGENCY_STOP_EN
    estop = 1'b0;
`endif
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (Level !== 2'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", Level); end
    n_checks++; if (AbreCierra !== 1'b0) begin n_fail++; $display("FAIL reset_door got %b exp 0", AbreCierra); end
    n_checks++; if (SubeBaja !== 1'b1) begin n_fail++; $display("FAIL reset_dir got %b exp 1", SubeBaja); end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving got %b exp 0", moving); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending got %b exp 0000", pending); end
  endtask

  task automatic test_single_trip();
    int n;
    do_reset();
    req_cab = 4'b1000;
    step();
    req_cab = '0;
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL trip_depart0 moving got %b exp 0", moving); end
    n_checks++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL trip_pending got %b exp 1000", pending); end
    step();
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL trip_depart1 moving got %b exp 0", moving); end
    step();
    n_checks++; if (moving !== 1'b1 || SubeBaja !== 1'b1) begin n_fail++; $display("FAIL trip_start moving/dir got %b%b exp 11", moving, SubeBaja); end
    pulse_tick();
    pulse_tick();
    n_checks++; if (Level !== 2'd2 || moving !== 1'b1) begin n_fail++; $display("FAIL trip_pass level/moving got %0d/%b exp 2/1", Level, moving); end
    pulse_tick();
    n_checks++; if (Level !== 2'd3 || AbreCierra !== 1'b1 || moving !== 1'b0) begin n_fail++; $display("FAIL trip_arrive level/door/moving got %0d/%b/%b exp 3/1/0", Level, AbreCierra, moving); end
    wait_door_closed(n);
    n_checks++; if (n !== DT) begin n_fail++; $display("FAIL trip_door_time got %0d exp %0d", n, DT); end
    step_n(3);
    n_checks++; if (moving !== 1'b0 || pending !== 4'b0000 || SubeBaja !== 1'b0) begin n_fail++; $display("FAIL trip_idle moving/pending/dir got %b/%b/%b exp 0/0000/0", moving, pending, SubeBaja); end
  endtask

  task automatic test_pass_through();
    int n;
    do_reset();
    req_dn = 4'b0100;
    req_cab = 4'b1000;
    step();
    req_dn = '0;
    req_cab = '0;
    wait_moving(n);
    n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL pass_start moving got %b exp 1", moving); end
    pulse_tick();
    pulse_tick();
    n_checks++; if (Level !== 2'd2 || AbreCierra !== 1'b0 || moving !== 1'b1) begin n_fail++; $display("FAIL pass_floor2 level/door/moving got %0d/%b/%b exp 2/0/1", Level, AbreCierra, moving); end
    pulse_tick();
    n_checks++; if (Level !== 2'd3 || AbreCierra !== 1'b1 || SubeBaja !== 1'b0 || pending !== 4'b0100) begin n_fail++; $display("FAIL pass_top level/door/dir/pending got %0d/%b/%b/%b exp 3/1/0/0100", Level, AbreCierra, SubeBaja, pending); end
    wait_door_closed(n);
    wait_moving(n);
    n_checks++; if (moving !== 1'b1 || SubeBaja !== 1'b0) begin n_fail++; $display("FAIL pass_down moving/dir got %b/%b exp 1/0", moving, SubeBaja); end
    pulse_tick();
    n_checks++; if (Level !== 2'd2 || AbreCierra !== 1'b1 || moving !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL pass_stop2 level/door/moving/pending got %0d/%b/%b/%b exp 2/1/0/0000", Level, AbreCierra, moving, pending); end
  endtask

  task automatic test_reopen();
    int n;
    bit mv_seen;
    do_reset();
    req_cab = 4'b0010;
    step();
    req_cab = '0;
    wait_moving(n);
    pulse_tick();
    n_checks++; if (Level !== 2'd1 || AbreCierra !== 1'b1) begin n_fail++; $display("FAIL reopen_arrive level/door got %0d/%b exp 1/1", Level, AbreCierra); end
    step_n(DT - 1);
    door_reopen = 1'b1;
    step();
    door_reopen = 1'b0;
    n_checks++; if (AbreCierra !== 1'b1) begin n_fail++; $display("FAIL reopen_wins door got %b exp 1", AbreCierra); end
    n = 0;
    mv_seen = 1'b0;
    while (AbreCierra === 1'b1 && n < 40) begin step(); n++; mv_seen |= moving; end
    n_checks++; if (n !== DT) begin n_fail++; $display("FAIL reopen_time got %0d exp %0d", n, DT); end
    n_checks++; if (mv_seen !== 1'b0) begin n_fail++; $display("FAIL reopen_moving got %b exp 0", mv_seen); end
  endtask

  task automatic test_hall_at_door();
    int n;
    do_reset();
    req_cab = 4'b0010;
    step();
    req_cab = '0;
    wait_moving(n);
    pulse_tick();
    step_n(3);
    req_up = 4'b0010;
    step();
    req_up = '0;
    n_checks++; if (pending[1] !== 1'b0 || AbreCierra !== 1'b1) begin n_fail++; $display("FAIL hall_door pending1/door got %b/%b exp 0/1", pending[1], AbreCierra); end
    wait_door_closed(n);
    n_checks++; if (n !== DT) begin n_fail++; $display("FAIL hall_door_restart got %0d exp %0d", n, DT); end
  endtask

  task automatic test_reset_mid_moving();
    int n;
    do_reset();
    req_cab = 4'b1000;
    step();
    req_cab = '0;
    wait_moving(n);
    pulse_tick();
    pulse_tick();
    n_checks++; if (Level !== 2'd2 || moving !== 1'b1) begin n_fail++; $display("FAIL mid_pre level/moving got %0d/%b exp 2/1", Level, moving); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({Level, AbreCierra, SubeBaja, moving} !== 5'b00010 || pending !== 4'b0000) begin n_fail++; $display("FAIL mid_async lvl/door/dir/mov/pend got %0d/%b/%b/%b/%b exp 0/0/1/0/0000", Level, AbreCierra, SubeBaja, moving, pending); end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step_n(4);
    n_checks++; if (Level !== 2'd0 || moving !== 1'b0 || AbreCierra !== 1'b0) begin n_fail++; $display("FAIL mid_idle level/moving/door got %0d/%b/%b exp 0/0/0", Level, moving, AbreCierra); end
  endtask

`ifdef EMERGENCY_STOP_EN
  task automatic test_estop();
    int n;
    do_reset();
    req_cab = 4'b1000;
    step();
    req_cab = '0;
    wait_moving(n);
    pulse_tick();
    estop = 1'b1;
    step();
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL estop_halt moving got %b exp 0", moving); end
    pulse_tick();
    step_n(3);
    n_checks++; if (Level !== 2'd1 || moving !== 1'b0) begin n_fail++; $display("FAIL estop_tick level/moving got %0d/%b exp 1/0", Level, moving); end
    estop = 1'b0;
    step();
    n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL estop_resume moving got %b exp 1", moving); end
    pulse_tick();
    pulse_tick();
    n_checks++; if (Level !== 2'd3 || AbreCierra !== 1'b1) begin n_fail++; $display("FAIL estop_target level/door got %0d/%b exp 3/1", Level, AbreCierra); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      req_cab = ($urandom_range(0, 11) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      req_up  = ($urandom_range(0, 19) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      req_dn  = ($urandom_range(0, 19) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      floor_tick  = ($urandom_range(0, 2) == 0);
      door_reopen = ($urandom_range(0, 39) == 0);
`ifdef EMERGENCY_STOP_EN
      estop = ($urandom_range(0, 29) == 0);
`endif
      step();
      n_checks++; if (Level !== 2'(m_lvl)) begin n_fail++; $display("FAIL rnd_level c=%0d got %0d exp %0d", c, Level, m_lvl); end
      n_checks++; if (AbreCierra !== m_door) begin n_fail++; $display("FAIL rnd_door c=%0d got %b exp %b", c, AbreCierra, m_door); end
      n_checks++; if (SubeBaja !== 1'(m_dir)) begin n_fail++; $display("FAIL rnd_dir c=%0d got %b exp %0d", c, SubeBaja, m_dir); end
      n_checks++; if (moving !== m_mov) begin n_fail++; $display("FAIL rnd_moving c=%0d got %b exp %b", c, moving, m_mov); end
      n_checks++; if (pending !== (m_cab | m_up | m_dn)) begin n_fail++; $display("FAIL rnd_pending c=%0d got %b exp %b", c, pending, m_cab | m_up | m_dn); end
      n_checks++; if ((moving & AbreCierra) !== 1'b0) begin n_fail++; $display("FAIL rnd_interlock c=%0d got %b exp 0", c, moving & AbreCierra); end
    end
    req_cab = '0; req_up = '0; req_dn = '0;
    floor_tick = 1'b0; door_reopen = 1'b0;
`ifdef EMERGENCY_STOP_EN
    estop = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_pass_through();
    test_reopen();
    test_hall_at_door();
    test_reset_mid_moving();
`ifdef EMERGENCY_STOP_EN
    test_estop();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
